pc_reg_unit: RTL and testbench

//   Parametrised program-counter register. Generalises the single-bit D flip-flop to WIDTH

---
 rtl/pc_reg_unit_pkg.sv | 18 +
 rtl/pc_dff_rst.sv | 28 ++
 rtl/pc_reg_unit.sv | 144 ++++++++++++++
 tb/tb_pc_reg_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pc_reg_unit_pkg.sv
// Shared definitions for the fetch-stage program counter: FSM state codes,
// default geometry and the next-PC source selector.
package pc_reg_unit_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int DEFAULT_STEP       = 4;
  localparam int DEFAULT_ALIGN_BITS = 2;

  typedef enum logic [1:0] {
    PC_SRC_HOLD = 2'd0,
    PC_SRC_INC  = 2'd1,
    PC_SRC_BR   = 2'd2
  } pc_src_e;

endpackage

// File: rtl/pc_dff_rst.sv
// WIDTH-bit register with load enable and asynchronous active-low reset to RST_VAL.
module pc_dff_rst #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= RST_VAL;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pc_reg_unit.sv
// Program-counter register for the fetch stage: boot/run/halt control,
// sequential advance, branch load with alignment check, stall, and previous-PC tracking.
module pc_reg_unit
  import pc_reg_unit_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter int               STEP       = DEFAULT_STEP,
  parameter int               ALIGN_BITS = DEFAULT_ALIGN_BITS
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             STALL,
  input  logic             BR_TAKEN,
  input  logic [WIDTH-1:0] BR_TARGET,
  input  logic             HALT_REQ,
  input  logic             RESUME,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_PREV,
  output logic             PC_VALID,
  output logic             HALTED,
  output logic             MISALIGN
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [1:0]       state_q, state_d;
  logic             pc_valid_q, pc_valid_d;
  logic             halted_q, halted_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] pc_q, pc_d, pc_prev_q, pc_inc;
  logic             pc_en;
  logic             target_misaligned;
  pc_src_e          pc_src;

  // A zero-width alignment field means every target is acceptable.
  generate
    if (ALIGN_BITS == 0) begin : g_no_align
      assign target_misaligned = 1'b0;
    end else begin : g_align
      assign target_misaligned = |BR_TARGET[ALIGN_BITS-1:0];
    end
  endgenerate

  assign pc_inc = pc_q + STEP_W;

  always_comb begin
    state_d    = state_q;
    pc_valid_d = pc_valid_q;
    halted_d   = halted_q;
    misalign_d = 1'b0;
    pc_src     = PC_SRC_HOLD;
    case (state_q)
      ST_BOOT: begin
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
        halted_d   = 1'b0;
      end
      ST_RUN: begin
        if (HALT_REQ) begin
          state_d    = ST_HALT;
          pc_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (BR_TAKEN && target_misaligned) begin
          state_d    = ST_HALT;
          pc_valid_d = 1'b0;
          halted_d   = 1'b1;
          misalign_d = 1'b1;
        end else if (BR_TAKEN) begin
          pc_src = PC_SRC_BR;
        end else if (!STALL) begin
          pc_src = PC_SRC_INC;
        end
      end
      ST_HALT: begin
        if (RESUME && !HALT_REQ) begin
          state_d    = ST_RUN;
          pc_valid_d = 1'b1;
          halted_d   = 1'b0;
        end
      end
      default: begin
        state_d    = ST_BOOT;
        pc_valid_d = 1'b0;
        halted_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    case (pc_src)
      PC_SRC_INC: pc_d = pc_inc;
      PC_SRC_BR:  pc_d = BR_TARGET;
      default:    pc_d = pc_q;
    endcase
  end

  // Only a real change of value loads PC, so PC_PREV keeps the last distinct address.
  assign pc_en = (pc_d != pc_q);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_BOOT;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_valid_q <= pc_valid_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  pc_dff_rst #(
    .WIDTH  (WIDTH),
    .RST_VAL(RESET_VEC)
  ) u_pc (
    .clk  (CLK),
    .rst_n(RST_n),
    .en   (pc_en),
    .d    (pc_d),
    .q    (pc_q)
  );

  pc_dff_rst #(
    .WIDTH  (WIDTH),
    .RST_VAL(RESET_VEC)
  ) u_pc_prev (
    .clk  (CLK),
    .rst_n(RST_n),
    .en   (pc_en),
    .d    (pc_q),
    .q    (pc_prev_q)
  );

  assign PC       = pc_q;
  assign PC_PREV  = pc_prev_q;
  assign PC_VALID = pc_valid_q;
  assign HALTED   = halted_q;
  assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_pc_reg_unit.sv
// Self-checking bench for pc_reg_unit: vector table plus scoreboard queue,
// with hand-written reset and async-reset sequences.
module tb_pc_reg_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_prev;
    logic        valid;
    logic        halted;
    logic        misalign;
  } exp_t;

  typedef struct packed {
    logic        stall;
    logic        br;
    logic        halt_req;
    logic        resume;
    logic [31:0] target;
    exp_t        exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_prev;
  logic        pc_valid;
  logic        halted;
  logic        misalign;

  int   checks;
  int   errors;
  exp_t sb_q[$];
  vec_t vecs[21];

  pc_reg_unit #(
    .WIDTH     (32),
    .RESET_VEC (32'h0000_0000),
    .STEP      (4),
    .ALIGN_BITS(2)
  ) dut (
    .CLK      (clk),
    .RST_n    (rst_n),
    .STALL    (stall),
    .BR_TAKEN (br_taken),
    .BR_TARGET(br_target),
    .HALT_REQ (halt_req),
    .RESUME   (resume),
    .PC       (pc),
    .PC_PREV  (pc_prev),
    .PC_VALID (pc_valid),
    .HALTED   (halted),
    .MISALIGN (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic s, input logic b, input logic h, input logic r,
                                 input logic [31:0] t, input logic [31:0] p,
                                 input logic [31:0] pp, input logic v, input logic hl,
                                 input logic m);
    vec_t x;
    x.stall        = s;
    x.br           = b;
    x.halt_req     = h;
    x.resume       = r;
    x.target       = t;
    x.exp.pc       = p;
    x.exp.pc_prev  = pp;
    x.exp.valid    = v;
    x.exp.halted   = hl;
    x.exp.misalign = m;
    return x;
  endfunction

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s %s: got %h expected %h", tag, field, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checkField(tag, "pc", pc, e.pc);
    checkField(tag, "pc_prev", pc_prev, e.pc_prev);
    checkField(tag, "pc_valid", {31'd0, pc_valid}, {31'd0, e.valid});
    checkField(tag, "halted", {31'd0, halted}, {31'd0, e.halted});
    checkField(tag, "misalign", {31'd0, misalign}, {31'd0, e.misalign});
  endtask

  // Drive one cycle of inputs (caller sits between a negedge and the next posedge).
  task automatic applyStimulus(input vec_t v);
    stall     = v.stall;
    br_taken  = v.br;
    halt_req  = v.halt_req;
    resume    = v.resume;
    br_target = v.target;
    sb_q.push_back(v.exp);
  endtask

  task automatic stepAndCheck(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      checkOutput(tag, e);
    end
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    halt_req  = 1'b0;
    resume    = 1'b0;
    br_target = 32'h0;

    //              st br hr rs target         pc             pc_prev        v  h  m
    vecs[0]  = mkVec(0, 1, 0, 0, 32'h0000_0044, 32'h0000_0000, 32'h0000_0000, 1, 0, 0);
    vecs[1]  = mkVec(0, 0, 0, 0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 1, 0, 0);
    vecs[2]  = mkVec(0, 0, 0, 0, 32'h0000_0000, 32'h0000_0008, 32'h0000_0004, 1, 0, 0);
    vecs[3]  = mkVec(1, 0, 0, 0, 32'h0000_0000, 32'h0000_0008, 32'h0000_0004, 1, 0, 0);
    vecs[4]  = mkVec(1, 0, 0, 0, 32'h0000_0000, 32'h0000_0008, 32'h0000_0004, 1, 0, 0);
    vecs[5]  = mkVec(1, 1, 0, 0, 32'h0000_0100, 32'h0000_0100, 32'h0000_0008, 1, 0, 0);
    vecs[6]  = mkVec(0, 0, 0, 0, 32'h0000_0000, 32'h0000_0104, 32'h0000_0100, 1, 0, 0);
    vecs[7]  = mkVec(0, 1, 0, 0, 32'h0000_0102, 32'h0000_0104, 32'h0000_0100, 0, 1, 1);
    vecs[8]  = mkVec(1, 1, 0, 0, 32'h0000_0200, 32'h0000_0104, 32'h0000_0100, 0, 1, 0);
    vecs[9]  = mkVec(0, 0, 0, 1, 32'h0000_0000, 32'h0000_0104, 32'h0000_0100, 1, 0, 0);
    vecs[10] = mkVec(0, 1, 0, 0, 32'h0000_0010, 32'h0000_0010, 32'h0000_0104, 1, 0, 0);
    vecs[11] = mkVec(0, 0, 1, 0, 32'h0000_0000, 32'h0000_0010, 32'h0000_0104, 0, 1, 0);
    vecs[12] = mkVec(0, 0, 1, 1, 32'h0000_0000, 32'h0000_0010, 32'h0000_0104, 0, 1, 0);
    vecs[13] = mkVec(0, 0, 0, 1, 32'h0000_0000, 32'h0000_0010, 32'h0000_0104, 1, 0, 0);
    vecs[14] = mkVec(0, 0, 0, 0, 32'h0000_0000, 32'h0000_0014, 32'h0000_0010, 1, 0, 0);
    vecs[15] = mkVec(0, 1, 0, 0, 32'h0000_0014, 32'h0000_0014, 32'h0000_0010, 1, 0, 0);
    vecs[16] = mkVec(0, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0014, 1, 0, 0);
    vecs[17] = mkVec(0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 0);
    vecs[18] = mkVec(0, 1, 1, 0, 32'h0000_0103, 32'h0000_0000, 32'hFFFF_FFFC, 0, 1, 0);
    vecs[19] = mkVec(0, 0, 0, 1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 0);
    vecs[20] = mkVec(0, 1, 0, 0, 32'h0000_0200, 32'h0000_0200, 32'h0000_0000, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("in_reset", '{pc: 32'h0, pc_prev: 32'h0, valid: 1'b0, halted: 1'b0, misalign: 1'b0});

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("boot_pre_edge", '{pc: 32'h0, pc_prev: 32'h0, valid: 1'b0, halted: 1'b0, misalign: 1'b0});

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      stepAndCheck($sformatf("vec%0d", i));
    end

    // Asynchronous reset asserted between edges while running at 0x200.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", '{pc: 32'h0, pc_prev: 32'h0, valid: 1'b0, halted: 1'b0, misalign: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mkVec(0, 1, 0, 0, 32'h0000_0300, 32'h0, 32'h0, 1, 0, 0));
    stepAndCheck("post_reset_boot");
    applyStimulus(mkVec(0, 0, 0, 0, 32'h0, 32'h0000_0004, 32'h0, 1, 0, 0));
    stepAndCheck("post_reset_adv");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
